shift_sequencer: RTL and testbench

Multi-cycle shift unit for the EX stage: it executes SLL/SRL/SRA/ROTR one bit position per clock from a 5-bit shift amount. The SRA path replicates bit 31 into the vacated positions, the same fill rule as the 5-to-32 sign extender. The block owns the shift datapath register and the 5-bit countdown. It holds the pipeline through a stall output until the result is ready, and it is aborted by the hazard unit's flush.

---
 rtl/shift_sequencer.sv | 118 +++++++++++
 tb/tb_shift_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - one-bit-per-clock SLL/SRL/SRA/ROTR unit with pipeline stall and flush abort
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Data,
    input  logic [CNT_W-1:0] Shamt,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] step;
    logic             can_accept;
    logic             load;

    // Single-position shift; SRA copies the sign bit into the vacated MSB.
    always_comb begin
        step = sreg_q;
        case (op_q)
            OP_SLL:  step = {sreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, sreg_q[WIDTH-1:1]};
            OP_SRA:  step = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
            OP_ROTR: step = {sreg_q[0], sreg_q[WIDTH-1:1]};
            default: step = sreg_q;
        endcase
    end

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign load       = Start && can_accept && !Flush;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;

        if (Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        sreg_d = Data;
                        cnt_d  = Shamt;
                        op_d   = Op;
                        // A zero shift amount is a pass-through straight to DONE.
                        if (Shamt == '0) begin
                            state_d  = ST_DONE;
                            result_d = Data;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sreg_d = step;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = ST_DONE;
                        result_d = step;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign Busy   = (state_q == ST_SHIFT);
    assign Done   = (state_q == ST_DONE);
    assign Stall  = Busy || load;
    assign Result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and randomized checks of shift_sequencer against an arithmetic model
module tb_shift_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] Data = 32'h0;
    logic [4:0]  Shamt = 5'd0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    shift_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Data(Data),
        .Shamt(Shamt), .Flush(Flush), .Busy(Busy), .Stall(Stall),
        .Done(Done), .Result(Result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation result computed directly from the shift amount.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
        logic signed [31:0] sd;
        sd = d;
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'(sd >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    // Model: number of busy cycles still owed, the pending answer, and the visible result.
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
        end else if (Flush) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_result <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (Start) begin
                if (Shamt == 5'd0) begin
                    m_done   <= 1'b1;
                    m_result <= Data;
                end else begin
                    m_left <= int'(Shamt);
                    m_pend <= ref_shift(Op, Data, int'(Shamt));
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (check_en && !Reset) begin
            check("busy", 32'(Busy), 32'(m_left > 0));
            check("done", 32'(Done), 32'(m_done));
            check("result", Result, m_result);
            check("stall", 32'(Stall), 32'((m_left > 0) || (Start && !Flush)));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        Start = 1'b1;
        Op    = op;
        Data  = d;
        Shamt = s;
    endtask

    // Called in cycle 0 with Start set; returns with Done seen, cyc relative to cycle 0.
    task automatic wait_done(input int budget, output int cyc, output int busy_n, output int stall_n);
        cyc = 0;
        busy_n = 0;
        stall_n = 0;
        #1;
        if (Stall) stall_n++;
        tick();
        Start = 1'b0;
        cyc = 1;
        while (!Done && cyc < budget) begin
            #1;
            if (Busy) busy_n++;
            if (Stall) stall_n++;
            tick();
            cyc++;
        end
        check("done_within_budget", 32'(Done), 32'd1);
    endtask

    int cyc, busy_n, stall_n, done_seen;

    initial begin
        #2 Reset = 1'b1;
        tick();
        tick();
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_result", Result, 32'h0);
        check("reset_stall", 32'(Stall), 32'd0);
        Reset = 1'b0;
        check_en = 1'b1;
        tick();

        check("model_sra", ref_shift(2'b10, 32'h80000010, 4), 32'hF8000001);
        check("model_rotr", ref_shift(2'b11, 32'h00000001, 1), 32'h80000000);
        check("model_sll", ref_shift(2'b00, 32'h00000001, 31), 32'h80000000);

        start_op(2'b10, 32'h80000010, 5'd4);
        wait_done(40, cyc, busy_n, stall_n);
        check("sra_done_cycle", 32'(cyc), 32'd5);
        check("sra_result", Result, 32'hF8000001);
        check("sra_stall_cycles", 32'(stall_n), 32'd5);
        check("sra_stall_in_done", 32'(Stall), 32'd0);
        tick();

        start_op(2'b00, 32'h00000001, 5'd31);
        wait_done(40, cyc, busy_n, stall_n);
        check("sll31_done_cycle", 32'(cyc), 32'd32);
        check("sll31_result", Result, 32'h80000000);
        check("sll31_busy_cycles", 32'(busy_n), 32'd31);
        tick();

        start_op(2'b01, 32'h1234ABCD, 5'd0);
        wait_done(5, cyc, busy_n, stall_n);
        check("pass_done_cycle", 32'(cyc), 32'd1);
        check("pass_result", Result, 32'h1234ABCD);
        start_op(2'b11, 32'h00000001, 5'd1);
        wait_done(5, cyc, busy_n, stall_n);
        check("b2b_done_cycle", 32'(cyc + 1), 32'd3);
        check("b2b_result", Result, 32'h80000000);
        tick();

        start_op(2'b01, 32'hFFFFFFFF, 5'd8);
        tick();
        Start = 1'b0;
        tick();
        Start = 1'b1;
        Op = 2'b00;
        tick();
        Start = 1'b0;
        check("ignored_start_busy", 32'(Busy), 32'd1);
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_busy", 32'(Busy), 32'd0);
        check("flush_done", 32'(Done), 32'd0);
        check("flush_result_kept", Result, 32'h80000000);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done) done_seen++;
            tick();
        end
        check("flush_no_done", 32'(done_seen), 32'd0);

        start_op(2'b00, 32'h0000FFFF, 5'd10);
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_result", Result, 32'h0);
        check("rst_mid_done", 32'(Done), 32'd0);
        tick();
        Reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done) done_seen++;
            tick();
        end
        check("rst_no_done", 32'(done_seen), 32'd0);

        start_op(2'b00, 32'h00000003, 5'd2);
        Flush = 1'b1;
        #1;
        check("start_flush_stall", 32'(Stall), 32'd0);
        tick();
        Start = 1'b0;
        Flush = 1'b0;
        check("start_flush_idle", 32'(Busy), 32'd0);
        tick();
        start_op(2'b00, 32'h00000003, 5'd2);
        wait_done(10, cyc, busy_n, stall_n);
        check("after_flush_cycle", 32'(cyc), 32'd3);
        check("after_flush_result", Result, 32'h0000000C);
        tick();

        for (int i = 0; i < 3000; i++) begin
            Start = 1'($urandom_range(0, 1));
            Op    = 2'($urandom);
            Data  = $urandom;
            Shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            Flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        Start = 1'b0;
        Flush = 1'b0;
        tick();
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
